// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: EXE-stage multiply/divide sequencer with MADD/MSUB accumulation and flush abort
module mdu_seq_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    input  logic        exe_adv,
    output logic        mdu_stall,
    output logic        mdu_finish,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV, DONE} state_t;
    state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, hi_out_q, hi_out_d, lo_out_q, lo_out_d;
    logic        fin_q, fin_d;
    logic        in_mul, in_div, sgn, acc, sub, qbit, qneg, rneg;
    logic [31:0] a_mag_in, b_mag, rem_nx, quo_nx, q_fix, r_fix;
    logic [32:0] shl, diff;
    logic [63:0] ext_a, ext_b, prod, mul_res;

    assign in_div   = (mdu_op == 4'd3) || (mdu_op == 4'd4);
    assign in_mul   = (mdu_op == 4'd1) || (mdu_op == 4'd2) || (mdu_op >= 4'd5 && mdu_op <= 4'd8);
    assign a_mag_in = (mdu_op[0] && src_a[31]) ? -src_a : src_a;
    // Odd op codes are the signed variants; 5..8 accumulate, 7..8 subtract
    assign sgn      = op_q[0];
    assign acc      = op_q >= 4'd5;
    assign sub      = op_q >= 4'd7;
    assign ext_a    = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b    = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod     = ext_a * ext_b;
    assign mul_res  = !acc ? prod : sub ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
    assign b_mag    = (sgn && b_q[31]) ? -b_q : b_q;
    assign shl      = {rem_q, quo_q[31]};
    assign diff     = shl - {1'b0, b_mag};
    assign qbit     = !diff[32];
    assign rem_nx   = qbit ? diff[31:0] : shl[31:0];
    assign quo_nx   = {quo_q[30:0], qbit};
    assign qneg     = sgn && (a_q[31] ^ b_q[31]);
    assign rneg     = sgn && a_q[31];
    assign q_fix    = qneg ? -quo_nx : quo_nx;
    assign r_fix    = rneg ? -rem_nx : rem_nx;

    assign mdu_stall  = !rst && !flush && ((state_q == IDLE && (in_mul || in_div)) ||
                        state_q == BUSY_MUL || state_q == BUSY_DIV);
    assign mdu_finish = fin_q;
    assign hi_out     = hi_out_q;
    assign lo_out     = lo_out_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_out_d = hi_out_q;
        lo_out_d = lo_out_q;
        fin_d    = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (in_mul || in_div) begin
                    a_d   = src_a;
                    b_d   = src_b;
                    hi_d  = hi_in;
                    lo_d  = lo_in;
                    op_d  = mdu_op;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = a_mag_in;
                    if (in_div && src_b == 32'd0) begin
                        state_d  = DONE;
                        hi_out_d = src_a;
                        lo_out_d = '1;
                        fin_d    = 1'b1;
                    end else begin
                        state_d = in_div ? BUSY_DIV : BUSY_MUL;
                    end
                end
                BUSY_MUL: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                        state_d  = DONE;
                        hi_out_d = mul_res[63:32];
                        lo_out_d = mul_res[31:0];
                        fin_d    = 1'b1;
                    end
                end
                BUSY_DIV: begin
                    cnt_d = cnt_q + 5'd1;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        hi_out_d = r_fix;
                        lo_out_d = q_fix;
                        fin_d    = 1'b1;
                    end
                end
                default: state_d = exe_adv ? IDLE : DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_out_q <= hi_out_d;
            lo_out_q <= lo_out_d;
            fin_q    <= fin_d;
        end
    end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: directed-vector bench for the MDU sequencer with MUL_CYCLES=2
module tb_mdu_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush, exe_adv;
    logic [3:0]  mdu_op;
    logic [31:0] src_a, src_b, hi_in, lo_in;
    logic        mdu_stall, mdu_finish;
    logic [31:0] hi_out, lo_out;
    int          errors = 0;
    int          checks = 0;

    mdu_seq_ctrl #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mdu_op(mdu_op), .src_a(src_a), .src_b(src_b),
        .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .exe_adv(exe_adv),
        .mdu_stall(mdu_stall), .mdu_finish(mdu_finish), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // Issues an op, holds it while stalled, watches 4 DONE cycles, then advances EXE
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                          output int stalls, output int fin_at, output int pulses);
        stalls = 0;
        pulses = 0;
        fin_at = -1;
        mdu_op = op; src_a = a; src_b = b; hi_in = hi; lo_in = lo; exe_adv = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (mdu_stall) stalls++;
            if (mdu_finish) begin
                pulses++;
                if (fin_at < 0) fin_at = c;
            end
            if (fin_at >= 0 && c == fin_at + 3) break;
            @(posedge clk); #1;
        end
        exe_adv = 1'b1;
        @(posedge clk); #1;
        exe_adv = 1'b0;
        mdu_op = 4'd0;
    endtask

    task automatic expect_op(input string name, input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                             input int e_stalls, input logic [31:0] e_hi, e_lo);
        int s, f, p;
        run_op(op, a, b, hi, lo, s, f, p);
        checks += 5;
        if (s !== e_stalls) begin errors++; $display("FAIL %s stalls got %0d exp %0d", name, s, e_stalls); end
        if (f !== e_stalls) begin errors++; $display("FAIL %s finish_cycle got %0d exp %0d", name, f, e_stalls); end
        if (p !== 1) begin errors++; $display("FAIL %s finish_pulses got %0d exp 1", name, p); end
        if (hi_out !== e_hi) begin errors++; $display("FAIL %s hi_out got %h exp %h", name, hi_out, e_hi); end
        if (lo_out !== e_lo) begin errors++; $display("FAIL %s lo_out got %h exp %h", name, lo_out, e_lo); end
    endtask

    task automatic test_reset();
        rst = 1'b1; mdu_op = 4'd1; flush = 1'b0; exe_adv = 1'b0;
        src_a = 32'd7; src_b = 32'd9; hi_in = 32'd0; lo_in = 32'd0;
        @(posedge clk); #1;
        checks += 4;
        if (mdu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", mdu_stall); end
        if (mdu_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b exp 0", mdu_finish); end
        if (hi_out !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi_out); end
        if (lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo_out); end
        rst = 1'b0; mdu_op = 4'd0;
        @(posedge clk); #1;
        checks++;
        if (mdu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", mdu_stall); end
    endtask

    task automatic test_mult();
        expect_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 3, 32'hFFFFFFFF, 32'hFFFFFFF1);
    endtask

    task automatic test_back_to_back();
        expect_op("b2b_madd", 4'd5, 32'd4, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 3, 32'h0, 32'h5);
    endtask

    task automatic test_div();
        expect_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        expect_op("divu", 4'd4, 32'd100, 32'd7, 32'd0, 32'd0, 33, 32'd2, 32'd14);
        expect_op("div_min", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 33, 32'd0, 32'h80000000);
        expect_op("div_mix", 4'd3, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 33, 32'd1, 32'hFFFFFFFD);
    endtask

    task automatic test_div_zero();
        expect_op("divu_zero", 4'd4, 32'h1234, 32'd0, 32'd0, 32'd0, 1, 32'h1234, 32'hFFFFFFFF);
    endtask

    task automatic test_accum();
        expect_op("maddu", 4'd6, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 3, 32'd1, 32'd0);
        expect_op("msub", 4'd7, 32'd2, 32'd3, 32'd0, 32'd0, 3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        expect_op("msubu", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 3, 32'h1, 32'hFFFFFFFF);
    endtask

    task automatic test_flush();
        int p = 0;
        mdu_op = 4'd3; src_a = 32'd100; src_b = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        checks++;
        if (mdu_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", mdu_stall); end
        @(posedge clk); #1;
        flush = 1'b0; mdu_op = 4'd0;
        for (int c = 0; c < 40; c++) begin
            if (mdu_finish) p++;
            @(posedge clk); #1;
        end
        checks += 3;
        if (p !== 0) begin errors++; $display("FAIL flush_no_finish got %0d exp 0", p); end
        if (hi_out !== 32'h1) begin errors++; $display("FAIL flush_hi got %h exp 00000001", hi_out); end
        if (lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_lo got %h exp ffffffff", lo_out); end
        expect_op("multu_after_flush", 4'd2, 32'd3, 32'd4, 32'd0, 32'd0, 3, 32'd0, 32'd12);
    endtask

    task automatic test_flush_edges();
        int p = 0;
        mdu_op = 4'd4; src_a = 32'h55; src_b = 32'd0; flush = 1'b1;
        #1;
        checks++;
        if (mdu_stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall got %b exp 0", mdu_stall); end
        @(posedge clk); #1;
        flush = 1'b0; mdu_op = 4'd0;
        repeat (3) begin
            if (mdu_finish) p++;
            @(posedge clk); #1;
        end
        mdu_op = 4'd1; src_a = 32'd2; src_b = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mdu_op = 4'd0;
        repeat (4) begin
            if (mdu_finish) p++;
            @(posedge clk); #1;
        end
        checks += 3;
        if (p !== 0) begin errors++; $display("FAIL flush_edge_finish got %0d exp 0", p); end
        if (hi_out !== 32'd0) begin errors++; $display("FAIL flush_edge_hi got %h exp 0", hi_out); end
        if (lo_out !== 32'd12) begin errors++; $display("FAIL flush_edge_lo got %h exp 0000000c", lo_out); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_accum();
        test_flush();
        test_flush_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Sequencing controller for the EXE-stage multiply/divide resource. Accepts one MDU op per instruction and holds EXE via stall while it runs.
- Runs a multi-cycle multiply (fixed latency) or a 32-iteration restoring divide.
- Applies MADD/MSUB accumulation against current HI/LO. Delivers a one-cycle finish pulse with final HI/LO to the HILO register write port.
- Flush/exception aborts any op in flight with no architectural effect.

Parameters:
MUL_CYCLES, 2, multiply latency in BUSY_MUL cycles; legal 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mdu_op  in  4  EXE-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU; 9-15 treated as none
src_a  in  32  forwarded rs value (dividend / multiplicand)
src_b  in  32  forwarded rt value (divisor / multiplier)
hi_in  in  32  current HI register value
lo_in  in  32  current LO register value
flush  in  1  EXE flush/exception; aborts op
exe_adv  in  1  EXE pipeline register loads next instruction this cycle
mdu_stall  out  1  hold IF..EXE
mdu_finish  out  1  one-cycle HI/LO write strobe
hi_out  out  32  final HI value
lo_out  out  32  final LO value

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE, counter 0, mdu_finish 0, hi_out 0, lo_out 0. mdu_stall=0 while rst=1 and after reset.
- States: IDLE, BUSY_MUL, BUSY_DIV, DONE.
- IDLE, op valid, flush=0:
  - Latch src_a, src_b, hi_in, lo_in and op kind; clear counter.
  - Multiply class (1,2,5-8) -> BUSY_MUL. Divide class (3,4) -> BUSY_DIV.
  - DIV/DIVU with src_b=0 -> DONE directly, quotient 32'hFFFFFFFF, remainder src_a.
- BUSY_MUL:
  - Product = 64-bit signed (1,5,7) or unsigned (2,6,8) of latched operands.
  - Counter increments; after MUL_CYCLES cycles -> DONE.
  - MADD*: result = {hi,lo}latched + product. MSUB*: result = {hi,lo}latched - product. Both mod 2^64.
- BUSY_DIV:
  - Restoring divide on magnitudes (signed ops take abs; abs(0x80000000)=0x80000000 unsigned).
  - One quotient bit per cycle, 32 cycles, then -> DONE.
  - Sign fix: quotient negated if operand signs differ; remainder takes dividend sign.
  - lo_out=quotient, hi_out=remainder.
- Entry to DONE: hi_out/lo_out registered. mdu_finish=1 for exactly the first DONE cycle, then 0.
- DONE: hi_out/lo_out hold. Stay until exe_adv=1 -> IDLE. The op still visible on mdu_op is never restarted.
- mdu_stall (combinational):
  - 1 in IDLE with valid op and flush=0.
  - 1 in BUSY_MUL and BUSY_DIV.
  - 0 in DONE and otherwise.
- Latency from start cycle T:
  - Multiply: stall T..T+MUL_CYCLES, finish at T+MUL_CYCLES+1.
  - Divide: stall T..T+32, finish at T+33.
  - Divide by zero: stall at T only, finish at T+1.
- flush=1 (any state): next state IDLE, counter cleared, mdu_finish 0 next cycle, hi_out/lo_out unchanged. mdu_stall=0 combinationally that cycle.
- Priority:
  - rst over everything.
  - flush over start.
  - flush in the DONE entry cycle suppresses finish (finish registered from next-state=DONE and flush=0).
- exe_adv during BUSY_* is ignored; stall forbids it upstream.
- Back-to-back ops: DONE->IDLE on exe_adv; the new op starts the following cycle, reading hi_in/lo_in already updated by the prior finish.

Test Plan:
- MULT, src_a=32'hFFFFFFFD, src_b=5, MUL_CYCLES=2 -> stall 3 cycles, finish at T+3, hi_out=FFFFFFFF, lo_out=FFFFFFF1.
- DIV, src_a=-7, src_b=2 -> 33 stall cycles, finish at T+33, lo_out=FFFFFFFD, hi_out=FFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU, src_b=0, src_a=0x1234 -> finish at T+1, lo_out=FFFFFFFF, hi_out=00001234.
- MADDU, hi_in=0, lo_in=FFFFFFFF, operands 1,1 -> hi_out=1, lo_out=0. MSUB, hi/lo=0, operands 2,3 -> hi_out=FFFFFFFF, lo_out=FFFFFFFA.
- DIV started, flush at iteration 10 -> stall 0 same cycle, no finish ever, hi_out/lo_out unchanged. Next MULTU 3*4 completes normally with lo_out=12.
- MULT finishes, exe_adv held 0 for 3 DONE cycles -> exactly one finish pulse, no restart. exe_adv=1 -> IDLE. Back-to-back MADD reads the updated HI/LO.
